// File: rtl/lstm_pkg.sv
// Shared types and fixed-point helpers for the LSTM cell.
// All helpers work on 64-bit signed values; callers truncate the result.
package lstm_pkg;

  typedef enum logic [2:0] {
    IDLE, MAC, ACT, CELL, HOUT, DONE
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 24;

  localparam logic signed [63:0] ONE =
    64'sd1 <<< DEF_FRAC;
  localparam logic signed [63:0] SAT_MAX =
    (64'sd1 <<< (DEF_WIDTH - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN =
    -(64'sd1 <<< (DEF_WIDTH - 1));

  function automatic logic signed [63:0] lim(
    input logic signed [63:0] v,
    input logic signed [63:0] lo,
    input logic signed [63:0] hi
  );
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Clamp to the range of a w-bit two's complement word.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int w
  );
    return lim(v, -(64'sd1 <<< (w - 1)),
               (64'sd1 <<< (w - 1)) - 64'sd1);
  endfunction

  // Piecewise-linear tanh: identity clipped to [-1, 1].
  function automatic logic signed [63:0] tanh_pwl(
    input logic signed [63:0] v,
    input int f
  );
    return lim(v, -(64'sd1 <<< f), 64'sd1 <<< f);
  endfunction

  // Piecewise-linear sigmoid: 0.5 + v/4 clipped to [0, 1].
  function automatic logic signed [63:0] sigm_pwl(
    input logic signed [63:0] v,
    input int f
  );
    return lim((64'sd1 <<< (f - 1)) + (v >>> 2),
               64'sd0, 64'sd1 <<< f);
  endfunction

endpackage

// File: rtl/lstm_cell_seq_if.sv
// Handshake and data bundle between the LSTM cell and its user.
// master = upstream/downstream user, slave = the cell.
interface lstm_cell_seq_if #(
  parameter int WIDTH = 32,
  parameter int N     = 76
);
  logic             i_valid;
  logic             o_ready;
  logic             i_clr_state;
  logic [N*WIDTH-1:0] i_x;
  logic [N*WIDTH-1:0] i_w_a;
  logic [N*WIDTH-1:0] i_w_i;
  logic [N*WIDTH-1:0] i_w_f;
  logic [N*WIDTH-1:0] i_w_o;
  logic [WIDTH-1:0] i_b_a;
  logic [WIDTH-1:0] i_b_i;
  logic [WIDTH-1:0] i_b_f;
  logic [WIDTH-1:0] i_b_o;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_a;
  logic [WIDTH-1:0] o_i;
  logic [WIDTH-1:0] o_f;
  logic [WIDTH-1:0] o_o;
  logic [WIDTH-1:0] o_c;
  logic [WIDTH-1:0] o_h;

  modport master (
    output i_valid, i_clr_state, i_x,
    output i_w_a, i_w_i, i_w_f, i_w_o,
    output i_b_a, i_b_i, i_b_f, i_b_o,
    output i_ready,
    input  o_ready, o_valid,
    input  o_a, o_i, o_f, o_o, o_c, o_h
  );

  modport slave (
    input  i_valid, i_clr_state, i_x,
    input  i_w_a, i_w_i, i_w_f, i_w_o,
    input  i_b_a, i_b_i, i_b_f, i_b_o,
    input  i_ready,
    output o_ready, o_valid,
    output o_a, o_i, o_f, o_o, o_c, o_h
  );
endinterface

// File: rtl/lstm_mac.sv
// One gate accumulator: bias load, one scaled product per step,
// saturated pre-activation out.
module lstm_mac
  import lstm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int ACC_W = 47
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic signed [WIDTH-1:0] bias,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] w,
  output logic signed [WIDTH-1:0] pre
);

  logic signed [ACC_W-1:0]   acc;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] term;
  logic signed [63:0]        acc64;

  assign prod  = (2*WIDTH)'(x) * (2*WIDTH)'(w);
  assign term  = prod >>> FRAC;
  assign acc64 = 64'(acc);
  assign pre   = WIDTH'(saturate(acc64, WIDTH));

  // Accumulate: bias on accept, then one product per MAC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'(bias);
    end else if (step) begin
      acc <= acc + ACC_W'(term);
    end
  end

endmodule

// File: rtl/lstm_cell_seq.sv
// Sequential LSTM cell: serial MAC over N inputs for four gates,
// then activations, cell state and hidden output.
module lstm_cell_seq
  import lstm_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int NUM      = 68,
  parameter int NUM_LSTM = 8
) (
  input logic          clk,
  input logic          rst,
  lstm_cell_seq_if.slave bus
);

  localparam int N  = NUM + NUM_LSTM;
  localparam int IW = $clog2(N + 1);
  // A scaled product alone spans 2*WIDTH-FRAC bits; the sum of
  // N of them plus the bias needs clog2(N+1) more.
  localparam int ACC_W = 2*WIDTH - FRAC + $clog2(N + 1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t state, nxt;
  logic   load, step;
  logic   clr;
  logic [IW-1:0]      idx;
  logic [N*WIDTH-1:0] xr;

  logic signed [WIDTH-1:0] xk;
  logic signed [WIDTH-1:0] wa, wi, wf, wo;
  logic signed [WIDTH-1:0] pa, pi, pf, po;
  logic signed [WIDTH-1:0] a_q, i_q, f_q, o_q;
  logic signed [WIDTH-1:0] c_q, h_q, cst;
  logic signed [WIDTH-1:0] c_nx, h_nx;
  logic signed [63:0]      cprev;

  assign xk = xr[int'(idx)*WIDTH +: WIDTH];
  assign wa = bus.i_w_a[int'(idx)*WIDTH +: WIDTH];
  assign wi = bus.i_w_i[int'(idx)*WIDTH +: WIDTH];
  assign wf = bus.i_w_f[int'(idx)*WIDTH +: WIDTH];
  assign wo = bus.i_w_o[int'(idx)*WIDTH +: WIDTH];

  lstm_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac_a (
    .clk(clk), .rst(rst), .load(load), .step(step),
    .bias(bus.i_b_a), .x(xk), .w(wa), .pre(pa)
  );
  lstm_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac_i (
    .clk(clk), .rst(rst), .load(load), .step(step),
    .bias(bus.i_b_i), .x(xk), .w(wi), .pre(pi)
  );
  lstm_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac_f (
    .clk(clk), .rst(rst), .load(load), .step(step),
    .bias(bus.i_b_f), .x(xk), .w(wf), .pre(pf)
  );
  lstm_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac_o (
    .clk(clk), .rst(rst), .load(load), .step(step),
    .bias(bus.i_b_o), .x(xk), .w(wo), .pre(po)
  );

  assign cprev = clr ? 64'sd0 : 64'(cst);
  assign c_nx  = WIDTH'(saturate(
    ((64'(a_q) * 64'(i_q)) >>> FRAC) +
    ((64'(f_q) * cprev) >>> FRAC), WIDTH));
  assign h_nx  = WIDTH'(saturate(
    (tanh_pwl(64'(c_q), FRAC) * 64'(o_q)) >>> FRAC, WIDTH));

  assign bus.o_ready = (state == IDLE);
  assign bus.o_valid = (state == DONE);
  assign bus.o_a = a_q;
  assign bus.o_i = i_q;
  assign bus.o_f = f_q;
  assign bus.o_o = o_q;
  assign bus.o_c = c_q;
  assign bus.o_h = h_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and MAC controls.
  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_valid) begin
          nxt  = MAC;
          load = 1'b1;
        end
      end
      MAC: begin
        step = 1'b1;
        if (idx == LAST) nxt = ACT;
      end
      ACT:  nxt = CELL;
      CELL: nxt = HOUT;
      HOUT: nxt = DONE;
      DONE: if (bus.i_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: input capture, index, gate/cell/hidden registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      xr  <= '0;
      clr <= 1'b0;
      cst <= '0;
      a_q <= '0;
      i_q <= '0;
      f_q <= '0;
      o_q <= '0;
      c_q <= '0;
      h_q <= '0;
    end else begin
      if (load) begin
        xr  <= bus.i_x;
        clr <= bus.i_clr_state;
        idx <= '0;
      end
      if (step) begin
        idx <= (idx == LAST) ? '0 : idx + IW'(1);
      end
      if (state == ACT) begin
        a_q <= WIDTH'(tanh_pwl(64'(pa), FRAC));
        i_q <= WIDTH'(sigm_pwl(64'(pi), FRAC));
        f_q <= WIDTH'(sigm_pwl(64'(pf), FRAC));
        o_q <= WIDTH'(sigm_pwl(64'(po), FRAC));
      end
      if (state == CELL) begin
        c_q <= c_nx;
        cst <= c_nx;
      end
      if (state == HOUT) begin
        h_q <= h_nx;
      end
    end
  end

endmodule

// File: tb/tb_lstm_cell_seq.sv
// Self-checking bench for lstm_cell_seq (N = 3).
// Reference: integer fixed-point model with floor division.
module tb_lstm_cell_seq;

  localparam int W  = 32;
  localparam int NN = 3;
  localparam longint ONE  = 64'sd16777216;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    longint a, i, f, o, c, h;
  } exp_t;

  logic clk;
  logic rst;

  lstm_cell_seq_if #(.WIDTH(W), .N(NN)) bus ();

  lstm_cell_seq #(
    .WIDTH(32), .FRAC(24), .NUM(2), .NUM_LSTM(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  longint vx[NN];
  longint vw[4][NN];
  longint vb[4];
  longint mc;
  exp_t   q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint fdiv(input longint a, input longint d);
    longint r;
    r = a / d;
    if ((a % d != 0) && ((a < 0) != (d < 0))) r = r - 1;
    return r;
  endfunction

  function automatic longint clampv(input longint v,
                                    input longint lo,
                                    input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint sig(input longint v);
    return clampv(ONE / 2 + fdiv(v, 4), 0, ONE);
  endfunction

  function automatic exp_t model(input longint cprev);
    exp_t   e;
    longint pre[4];
    longint acc;
    for (int g = 0; g < 4; g++) begin
      acc = vb[g];
      for (int k = 0; k < NN; k++)
        acc = acc + fdiv(vx[k] * vw[g][k], ONE);
      pre[g] = clampv(acc, SMIN, SMAX);
    end
    e.a = clampv(pre[0], -ONE, ONE);
    e.i = sig(pre[1]);
    e.f = sig(pre[2]);
    e.o = sig(pre[3]);
    e.c = clampv(fdiv(e.a * e.i, ONE) + fdiv(e.f * cprev, ONE),
                 SMIN, SMAX);
    e.h = clampv(fdiv(clampv(e.c, -ONE, ONE) * e.o, ONE),
                 SMIN, SMAX);
    return e;
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint expv, input longint tol);
    longint d;
    checks++;
    d = act - expv;
    if (d < 0) d = -d;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, expv, expv);
    end
  endtask

  function automatic longint rnd();
    return longint'(int'($urandom_range(0, 67108864))) - 64'sd33554432;
  endfunction

  task automatic rand_vec();
    for (int k = 0; k < NN; k++) begin
      vx[k] = rnd();
      for (int g = 0; g < 4; g++) vw[g][k] = rnd();
    end
    for (int g = 0; g < 4; g++) vb[g] = rnd();
  endtask

  task automatic set_all(input longint xv, input longint wv);
    for (int k = 0; k < NN; k++) begin
      vx[k] = xv;
      for (int g = 0; g < 4; g++) vw[g][k] = wv;
    end
    for (int g = 0; g < 4; g++) vb[g] = 0;
  endtask

  task automatic apply();
    for (int k = 0; k < NN; k++) begin
      bus.i_x[k*W +: W]   = 32'(vx[k]);
      bus.i_w_a[k*W +: W] = 32'(vw[0][k]);
      bus.i_w_i[k*W +: W] = 32'(vw[1][k]);
      bus.i_w_f[k*W +: W] = 32'(vw[2][k]);
      bus.i_w_o[k*W +: W] = 32'(vw[3][k]);
    end
    bus.i_b_a = 32'(vb[0]);
    bus.i_b_i = 32'(vb[1]);
    bus.i_b_f = 32'(vb[2]);
    bus.i_b_o = 32'(vb[3]);
  endtask

  // One full transaction: accept, latency, optional DONE stall.
  task automatic run(input bit clr, input int hold, input bit keepv);
    exp_t e;
    int   n;
    @(negedge clk);
    apply();
    bus.i_clr_state = clr;
    bus.i_valid = 1'b1;
    chk("ready_idle", longint'(bus.o_ready), 1, 0);
    @(posedge clk);
    e = model(clr ? 64'sd0 : mc);
    mc = e.c;
    q.push_back(e);
    #1;
    if (!keepv) bus.i_valid = 1'b0;
    n = 0;
    while (!bus.o_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 6, 0);
    for (int j = 0; j < hold; j++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", longint'(bus.o_valid), 1, 0);
      chk("stall_ready", longint'(bus.o_ready), 0, 0);
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b0;
    chk("release_ready", longint'(bus.o_ready), 1, 0);
    chk("release_valid", longint'(bus.o_valid), 0, 0);
    if (q.size() != 0) e = q.pop_front();
  endtask

  // Per-cycle output check against the model while o_valid is high.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.o_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 1, 0, 0);
      end else begin
        e = q[0];
        chk("o_a", longint'($signed(bus.o_a)), e.a, 2);
        chk("o_i", longint'($signed(bus.o_i)), e.i, 2);
        chk("o_f", longint'($signed(bus.o_f)), e.f, 2);
        chk("o_o", longint'($signed(bus.o_o)), e.o, 2);
        chk("o_c", longint'($signed(bus.o_c)), e.c, 2);
        chk("o_h", longint'($signed(bus.o_h)), e.h, 2);
        chk("ready_in_done", longint'(bus.o_ready), 0, 0);
      end
    end
  end

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_a"}, longint'($signed(bus.o_a)), 0, 0);
    chk({tag, "_i"}, longint'($signed(bus.o_i)), 0, 0);
    chk({tag, "_f"}, longint'($signed(bus.o_f)), 0, 0);
    chk({tag, "_o"}, longint'($signed(bus.o_o)), 0, 0);
    chk({tag, "_c"}, longint'($signed(bus.o_c)), 0, 0);
    chk({tag, "_h"}, longint'($signed(bus.o_h)), 0, 0);
  endtask

  task automatic chk_zero_vec(input string tag);
    chk({tag, "_a"}, longint'($signed(bus.o_a)), 0, 0);
    chk({tag, "_i"}, longint'($signed(bus.o_i)), 64'h0080_0000, 0);
    chk({tag, "_f"}, longint'($signed(bus.o_f)), 64'h0080_0000, 0);
    chk({tag, "_o"}, longint'($signed(bus.o_o)), 64'h0080_0000, 0);
    chk({tag, "_c"}, longint'($signed(bus.o_c)), 0, 0);
    chk({tag, "_h"}, longint'($signed(bus.o_h)), 0, 0);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    longint cv;
    rst = 1'b1;
    mc  = 0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_clr_state = 1'b0;
    set_all(0, 0);
    apply();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", longint'(bus.o_ready), 1, 0);
    chk("rst_valid", longint'(bus.o_valid), 0, 0);
    chk_zero_outs("rst_out");
    @(negedge clk);
    rst = 1'b0;

    // All-zero vector.
    set_all(0, 0);
    run(1'b1, 0, 1'b0);
    chk_zero_vec("zero");

    // Bias-only tanh drive, sequence start then continuation.
    set_all(0, 0);
    vb[0] = 64'h0800_0000;
    run(1'b1, 0, 1'b0);
    chk("bias_c0", longint'($signed(bus.o_c)), 64'h0080_0000, 2);
    run(1'b0, 0, 1'b0);
    chk("bias_c1", longint'($signed(bus.o_c)), 64'h00C0_0000, 2);
    chk("bias_h1", longint'($signed(bus.o_h)), 64'h0060_0000, 2);

    // Huge operands must saturate, not wrap.
    set_all(64'h7F00_0000, 64'h7F00_0000);
    run(1'b1, 0, 1'b0);
    chk("sat_i", longint'($signed(bus.o_i)), 64'h0100_0000, 2);
    chk("sat_a", longint'($signed(bus.o_a)), 64'h0100_0000, 2);
    cv = longint'($signed(bus.o_c));
    chk("sat_c_ge1", longint'(cv >= 64'h0100_0000), 1, 0);
    chk("sat_c_le2", longint'(cv <= 64'h0200_0000), 1, 0);

    // Randomized sequences.
    for (int t = 0; t < 12; t++) begin
      rand_vec();
      run(($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of MAC.
    rand_vec();
    @(negedge clk);
    apply();
    bus.i_clr_state = 1'b0;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mc  = 0;
    #1;
    chk("mid_rst_ready", longint'(bus.o_ready), 1, 0);
    chk("mid_rst_valid", longint'(bus.o_valid), 0, 0);
    chk_zero_outs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_valid_after_rst", longint'(bus.o_valid), 0, 0);
    set_all(0, 0);
    run(1'b0, 0, 1'b0);
    chk_zero_vec("post_rst");

    // Long DONE stall with i_valid held high.
    rand_vec();
    run(1'b0, 10, 1'b1);
    @(posedge clk);
    #1;
    chk("no_accept_after", longint'(bus.o_ready), 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
